axi_mem_rd: RTL

Read-channel responder for the memory side of the AXI read fabric. It accepts one AR request at a time from the upstream read arbiter on `mem_r` and returns the data beats from an internal word array. It supports FIXED and INCR bursts, with WRAP selectable at build time. It sits in the simulation SoC where the arbiter's RAM-side port terminates. Write-channel outputs of the interface are tied inactive.

---
 rtl/axi_mem_rd.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_rd.sv
// AXI read-channel memory responder: one AR at a time, FIXED/INCR bursts from a word array.
// Build macro AXI_MEM_RD_WRAP_EN adds WRAP bursts; without it WRAP returns SLVERR.
module axi_mem_rd #(
  parameter int          DATA_W    = 64,
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_r_arvalid_i,
  output logic              mem_r_arready_o,
  input  logic [31:0]       mem_r_araddr_i,
  input  logic [3:0]        mem_r_arid_i,
  input  logic [7:0]        mem_r_arlen_i,
  input  logic [2:0]        mem_r_arsize_i,
  input  logic [1:0]        mem_r_arburst_i,
  output logic              mem_r_rvalid_o,
  input  logic              mem_r_rready_i,
  output logic [DATA_W-1:0] mem_r_rdata_o,
  output logic [1:0]        mem_r_rresp_o,
  output logic              mem_r_rlast_o,
  output logic [3:0]        mem_r_rid_o,
  output logic              mem_r_awready_o,
  output logic              mem_r_wready_o,
  output logic              mem_r_bvalid_o
);

  localparam int          NB       = DATA_W / 8;
  localparam int          LOG2NB_I = $clog2(NB);
  localparam logic [2:0]  LOG2NB   = 3'(LOG2NB_I);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_RESP} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            st_q, st_d;
  logic [31:0]       addr_q, addr_d, addr_nxt, inc;
  logic [3:0]        id_q, id_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d, ar_err;
  logic              ld;
  logic [31:0]       rd_addr, off, widx;
  logic              beat_bad;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
`ifdef AXI_MEM_RD_WRAP_EN
  logic [7:0]        len_q, len_d;
  logic [31:0]       win_mask;
`endif

  // Burst-level errors are decided once at AR acceptance and poison every beat.
  always_comb begin
    ar_err = (mem_r_arsize_i > LOG2NB) | (mem_r_arburst_i == 2'b11);
`ifdef AXI_MEM_RD_WRAP_EN
    if (mem_r_arburst_i == 2'b10 && !(mem_r_arlen_i inside {8'd1, 8'd3, 8'd7, 8'd15}))
      ar_err = 1'b1;
`else
    if (mem_r_arburst_i == 2'b10)
      ar_err = 1'b1;
`endif
  end

  always_comb begin
    inc      = 32'd1 << size_q;
    addr_nxt = addr_q;
`ifdef AXI_MEM_RD_WRAP_EN
    win_mask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
`endif
    case (burst_q)
      2'b01:   addr_nxt = addr_q + inc;
`ifdef AXI_MEM_RD_WRAP_EN
      2'b10:   addr_nxt = (addr_q & ~win_mask) | ((addr_q + inc) & win_mask);
`endif
      default: addr_nxt = addr_q;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    addr_d  = addr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
`ifdef AXI_MEM_RD_WRAP_EN
    len_d   = len_q;
`endif
    ld      = 1'b0;
    rd_addr = addr_q;
    case (st_q)
      ST_IDLE: begin
        if (mem_r_arvalid_i) begin
          addr_d  = mem_r_araddr_i;
          id_d    = mem_r_arid_i;
          cnt_d   = mem_r_arlen_i;
          size_d  = mem_r_arsize_i;
          burst_d = mem_r_arburst_i;
          err_d   = ar_err;
`ifdef AXI_MEM_RD_WRAP_EN
          len_d   = mem_r_arlen_i;
`endif
          st_d    = ST_READ;
        end
      end
      ST_READ: begin
        ld   = 1'b1;
        st_d = ST_RESP;
      end
      ST_RESP: begin
        if (mem_r_rready_i) begin
          if (cnt_q != 8'd0) begin
            addr_d  = addr_nxt;
            cnt_d   = cnt_q - 8'd1;
            ld      = 1'b1;
            rd_addr = addr_nxt;
          end else begin
            st_d = ST_IDLE;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    off      = rd_addr - BASE;
    widx     = off >> LOG2NB;
    beat_bad = err_q | (rd_addr < BASE) | (widx >= DEPTH_W);
    rdata_d  = beat_bad ? '0 : mem_q[widx[AW-1:0]];
    rresp_d  = beat_bad ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= ST_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
`ifdef AXI_MEM_RD_WRAP_EN
      len_q   <= '0;
`endif
    end else begin
      st_q    <= st_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
`ifdef AXI_MEM_RD_WRAP_EN
      len_q   <= len_d;
`endif
      if (ld) begin
        rdata_q <= rdata_d;
        rresp_q <= rresp_d;
      end
    end
  end

  // Outputs are masked by reset so a mid-burst reset silences the channel in the same cycle.
  assign mem_r_arready_o = ~reset & (st_q == ST_IDLE);
  assign mem_r_rvalid_o  = ~reset & (st_q == ST_RESP);
  assign mem_r_rlast_o   = mem_r_rvalid_o & (cnt_q == 8'd0);
  assign mem_r_rid_o     = mem_r_rvalid_o ? id_q : 4'd0;
  assign mem_r_rdata_o   = reset ? '0 : rdata_q;
  assign mem_r_rresp_o   = reset ? 2'b00 : rresp_q;
  assign mem_r_awready_o = 1'b0;
  assign mem_r_wready_o  = 1'b0;
  assign mem_r_bvalid_o  = 1'b0;

endmodule
